// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for Execute; stalls the pipeline until the result is ready.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational product.
module ex_muldiv_seq #(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         op_i,
   input  logic [D_WIDTH-1:0] rs1_i,
   input  logic [D_WIDTH-1:0] rs2_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               done_o,
   output logic [D_WIDTH-1:0] result_o
);
   localparam int W  = D_WIDTH;
   localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(D_WIDTH - 1);
   localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

   state_e          state_q;
   logic [CW-1:0]   count_q;
   logic [2*W-1:0]  acc_q;
   logic [W-1:0]    b_q;
   logic [2:0]      op_q;
   logic            neg_q, a_neg_q, done_q;
   logic [W-1:0]    result_q;

   logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, fast_go;
   logic [W-1:0]    a_mag, b_mag, fast_res, calc_res, quo, rem;
   logic [W:0]      mul_sum, trial;
   logic [2*W-1:0]  acc_d, prod;

   // Operand decode for the op arriving in IDLE.
   always_comb begin
      a_signed = ~((op_i == 3'b011) | (op_i[2] & op_i[0]));
      b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
      a_neg    = a_signed & rs1_i[W-1];
      b_neg    = b_signed & rs2_i[W-1];
      a_mag    = a_neg ? -rs1_i : rs1_i;
      b_mag    = b_neg ? -rs2_i : rs2_i;
      div_zero = op_i[2] & (rs2_i == '0);
      div_ovf  = op_i[2] & ~op_i[0] & (rs1_i == SMIN) & (&rs2_i);
      fast_go  = div_zero | div_ovf;
      if (div_zero) fast_res = op_i[1] ? rs1_i : '1;
      else          fast_res = op_i[1] ? '0 : SMIN;
`ifdef MULDIV_FAST_MUL_EN
      begin
         logic [2*W-1:0] fmul;
         fmul = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
         fmul = (a_neg ^ b_neg) ? -fmul : fmul;
         if (~op_i[2]) begin
            fast_go  = 1'b1;
            fast_res = (op_i[1:0] == 2'b00) ? fmul[W-1:0] : fmul[2*W-1:W];
         end
      end
`endif
   end

   // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
      trial   = acc_q[2*W-1:W-1] - {1'b0, b_q};
      if (op_q[2])
         acc_d = trial[W] ? {acc_q[2*W-2:0], 1'b0}
                          : {trial[W-1:0], acc_q[W-2:0], 1'b1};
      else
         acc_d = {mul_sum, acc_q[W-1:1]};
      prod = neg_q   ? -acc_d : acc_d;
      quo  = neg_q   ? -acc_d[W-1:0] : acc_d[W-1:0];
      rem  = a_neg_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
      case (op_q)
         3'b000:        calc_res = prod[W-1:0];
         3'b100, 3'b101: calc_res = quo;
         3'b110, 3'b111: calc_res = rem;
         default:       calc_res = prod[2*W-1:W];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i & ~flush_i) begin
               op_q    <= op_i;
               b_q     <= b_mag;
               neg_q   <= a_neg ^ b_neg;
               a_neg_q <= a_neg;
               acc_q   <= {{W{1'b0}}, a_mag};
               count_q <= '0;
               if (fast_go) begin
                  result_q <= fast_res;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q  <= CALC;
               end
            end
            CALC: if (flush_i) begin
               state_q <= IDLE;
            end else begin
               acc_q   <= acc_d;
               count_q <= count_q + CW'(1);
               if (count_q == LAST) begin
                  result_q <= calc_res;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall_o  = (state_q == CALC) | ((state_q == IDLE) & start_i & ~flush_i);
   assign done_o   = done_q;
   assign result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized and directed bench for ex_muldiv_seq against an arithmetic reference model.
module tb_ex_muldiv_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start_i, flush_i;
   logic [2:0]   op_i;
   logic [W-1:0] rs1_i, rs2_i;
   logic         stall_o, done_o;
   logic [W-1:0] result_o;
   logic [W-1:0] last_res;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_seq #(.D_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i),
      .rs2_i(rs2_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
      .result_o(result_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, ub;
      longint unsigned ua, ubu;
      logic [63:0]     p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'd0, b});
      ua  = {32'd0, a};
      ubu = {32'd0, b};
      p   = '0;
      case (op)
         3'd0: begin p = sa * sb;  return p[31:0];  end
         3'd1: begin p = sa * sb;  return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = ua * ubu; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) return 1;
`endif
      return W + 1;
   endfunction

   // Holds start_i high while stalled, as the pipeline would, and checks latency/stall/result.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int cyc, st, lat;
      logic [31:0] exp;
      exp = ref_res(op, a, b);
      lat = ref_lat(op, a, b);
      @(negedge clk);
      op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
      #1;
      cyc = 0; st = 0;
      while (!done_o && cyc < 100) begin
         if (stall_o) st++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_lat"}, cyc, lat);
      chk({tag, "_stall_cycles"}, st, lat);
      chk({tag, "_stall_at_done"}, stall_o, 0);
      chk({tag, "_result"}, result_o, exp);
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done_o, 0);
      chk({tag, "_held"}, result_o, exp);
      last_res = exp;
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
      last_res = '0;
      #1;
      chk("reset_stall", stall_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_result", result_o, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(3'd0, 32'h7, 32'hFFFF_FFFD, "mul_7x-3");
      run_op(3'd1, 32'h7, 32'hFFFF_FFFD, "mulh_7x-3");
      run_op(3'd4, 32'hFFFF_FFF9, 32'h2, "div_-7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'h2, "rem_-7/2");
      run_op(3'd5, 32'hFFFF_FFFF, 32'h10, "divu_big/16");
      run_op(3'd5, 32'h5, 32'h0, "divu_by0");
      run_op(3'd6, 32'h5, 32'h0, "rem_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_neg");

      // Asynchronous reset in the middle of an iterative divide.
      @(negedge clk);
      op_i = 3'd5; rs1_i = 32'h1234_5678; rs2_i = 32'h3; start_i = 1'b1;
      repeat (10) @(negedge clk);
      start_i = 1'b0; rst = 1'b1;
      #1;
      chk("midrst_stall", stall_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_result", result_o, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_idle_stall", stall_o, 0);
      run_op(3'd7, 32'd100, 32'd7, "remu_after_rst");

      // Flush aborts a divide: no done pulse, result untouched.
      @(negedge clk);
      op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd9; start_i = 1'b1;
      repeat (5) @(negedge clk);
      flush_i = 1'b1; start_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      begin
         int seen_done, seen_stall;
         seen_done = 0; seen_stall = 0;
         repeat (40) begin
            if (done_o) seen_done++;
            if (stall_o) seen_stall++;
            @(negedge clk);
         end
         chk("flush_no_done", seen_done, 0);
         chk("flush_no_stall", seen_stall, 0);
         chk("flush_result_held", result_o, last_res);
      end
      // Flush in IDLE suppresses start.
      op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle_flush_stall", stall_o, 0);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      #1;
      chk("idle_flush_no_start", stall_o, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");

      for (int i = 0; i < 60; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            3: b = $urandom_range(1, 300);
            default: ;
         endcase
         run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      end

      run_op(3'd0, 32'd1000, 32'd1000, "mul_1000x1000");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
